// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - shared kind/ALU/opcode/error constants for the instruction encoder-loader
package instr_encoder_loader_pkg;

  // Instruction classes
  localparam logic [3:0] KIND_OP     = 4'd0;
  localparam logic [3:0] KIND_OPIMM  = 4'd1;
  localparam logic [3:0] KIND_LUI    = 4'd2;
  localparam logic [3:0] KIND_AUIPC  = 4'd3;
  localparam logic [3:0] KIND_JAL    = 4'd4;
  localparam logic [3:0] KIND_JALR   = 4'd5;
  localparam logic [3:0] KIND_BRANCH = 4'd6;
  localparam logic [3:0] KIND_LOAD   = 4'd7;
  localparam logic [3:0] KIND_STORE  = 4'd8;
  localparam logic [3:0] KIND_HALT   = 4'd9;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;
  localparam logic [5:0] ALU_BEQ  = 6'd10;
  localparam logic [5:0] ALU_BNE  = 6'd11;
  localparam logic [5:0] ALU_BLT  = 6'd12;
  localparam logic [5:0] ALU_BGE  = 6'd13;
  localparam logic [5:0] ALU_BLTU = 6'd14;
  localparam logic [5:0] ALU_BGEU = 6'd15;
  localparam logic [5:0] ALU_LB   = 6'd16;
  localparam logic [5:0] ALU_LH   = 6'd17;
  localparam logic [5:0] ALU_LW   = 6'd18;
  localparam logic [5:0] ALU_LBU  = 6'd19;
  localparam logic [5:0] ALU_LHU  = 6'd20;
  localparam logic [5:0] ALU_SB   = 6'd21;
  localparam logic [5:0] ALU_SH   = 6'd22;
  localparam logic [5:0] ALU_SW   = 6'd23;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_FULL    = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_ERR} state_e;

  function automatic logic [2:0] funct3_of(input logic [5:0] alu);
    case (alu)
      ALU_ADD, ALU_SUB, ALU_BEQ, ALU_LB, ALU_SB: funct3_of = 3'd0;
      ALU_SLL, ALU_BNE, ALU_LH, ALU_SH:          funct3_of = 3'd1;
      ALU_SLT, ALU_LW, ALU_SW:                   funct3_of = 3'd2;
      ALU_SLTU:                                  funct3_of = 3'd3;
      ALU_XOR, ALU_BLT, ALU_LBU:                 funct3_of = 3'd4;
      ALU_SRL, ALU_SRA, ALU_BGE, ALU_LHU:        funct3_of = 3'd5;
      ALU_OR, ALU_BLTU:                          funct3_of = 3'd6;
      ALU_AND, ALU_BGEU:                         funct3_of = 3'd7;
      default:                                   funct3_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_loader_word_encoder.sv
// rtl/instr_encoder_loader_word_encoder.sv - combinational decoded fields -> RV32I word with legality/range flags
module instr_word_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [5:0]  alucode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       i_ok, sh_ok, b_ok, j_ok, u_ok, sh_op;

  assign f3    = funct3_of(alucode);
  assign f7    = (alucode == ALU_SUB || alucode == ALU_SRA) ? 7'b0100000 : 7'b0000000;
  assign i_ok  = (imm[31:11] == {21{imm[11]}});
  assign sh_ok = (imm[31:5] == 27'd0);
  assign b_ok  = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign j_ok  = (imm[31:20] == {12{imm[20]}}) && !imm[0];
  assign u_ok  = (imm[11:0] == 12'd0);
  assign sh_op = (alucode == ALU_SLL) || (alucode == ALU_SRL) || (alucode == ALU_SRA);

  always_comb begin
    word      = 32'd0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (kind)
      KIND_OP: begin
        illegal = (alucode > ALU_AND);
        word    = {f7, rs2, rs1, f3, rd, OPC_OP};
      end
      KIND_OPIMM: begin
        illegal = (alucode > ALU_AND) || (alucode == ALU_SUB);
        if (sh_op) begin
          range_err = !sh_ok;
          word      = {f7, imm[4:0], rs1, f3, rd, OPC_OPIMM};
        end else begin
          range_err = !i_ok;
          word      = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
        end
      end
      KIND_LUI, KIND_AUIPC: begin
        range_err = !u_ok;
        word      = {imm[31:12], rd, (kind == KIND_LUI) ? OPC_LUI : OPC_AUIPC};
      end
      KIND_JAL: begin
        range_err = !j_ok;
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      KIND_JALR: begin
        range_err = !i_ok;
        word      = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      end
      KIND_BRANCH: begin
        illegal   = (alucode < ALU_BEQ) || (alucode > ALU_BGEU);
        range_err = !b_ok;
        word      = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      KIND_LOAD: begin
        illegal   = (alucode < ALU_LB) || (alucode > ALU_LHU);
        range_err = !i_ok;
        word      = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      end
      KIND_STORE: begin
        illegal   = (alucode < ALU_SB) || (alucode > ALU_SW);
        range_err = !i_ok;
        word      = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      end
      KIND_HALT: word = {25'd0, OPC_SYSTEM};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes field bundles and writes them to imem; optional ENCODER_CHECKSUM_EN adds checksum output
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_kind,
  input  logic [5:0]        in_alucode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            state, state_nx;
  logic [31:0]       word;
  logic              illegal, range_err;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   wcount;
  logic              full, accept, do_write, set_err;
  logic [1:0]        code_nx;

  instr_word_encoder u_enc (
    .kind      (in_kind),
    .alucode   (in_alucode),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .imm       (in_imm),
    .word      (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  // wcount saturates at the depth because no write can follow the full error
  assign full     = wcount[ADDR_W];
  assign in_ready = (state == ST_LOAD);
  assign accept   = in_ready && in_valid && !start;

  always_comb begin
    state_nx = state;
    do_write = 1'b0;
    set_err  = 1'b0;
    code_nx  = ERR_NONE;
    if (start) begin
      state_nx = ST_LOAD;
    end else if (accept) begin
      if (illegal) begin
        set_err = 1'b1;
        code_nx = ERR_ILLEGAL;
      end else if (range_err) begin
        set_err = 1'b1;
        code_nx = ERR_RANGE;
      end else if (full) begin
        set_err = 1'b1;
        code_nx = ERR_FULL;
      end else begin
        do_write = 1'b1;
        if (in_last) state_nx = ST_DONE;
      end
      if (set_err) state_nx = ST_ERR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      addr_cnt   <= BASE;
      wcount     <= '0;
`ifdef ENCODER_CHECKSUM_EN
      checksum   <= 32'd0;
`endif
    end else begin
      state   <= state_nx;
      imem_we <= do_write;
      if (start) begin
        addr_cnt <= BASE;
        wcount   <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= ERR_NONE;
`ifdef ENCODER_CHECKSUM_EN
        checksum <= 32'd0;
`endif
      end
      if (do_write) begin
        imem_addr  <= addr_cnt;
        imem_wdata <= word;
        addr_cnt   <= addr_cnt + ADDR_W'(1);
        wcount     <= wcount + (ADDR_W + 1)'(1);
        if (in_last) done <= 1'b1;
`ifdef ENCODER_CHECKSUM_EN
        checksum   <= checksum + word;
`endif
      end
      if (set_err) begin
        err      <= 1'b1;
        err_code <= code_nx;
      end
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder. Accepts decoded-instruction fields one per handshake, re-encodes each into a 32-bit RV32I machine word, and writes it to instruction memory at consecutive word addresses.
- Sits between the test/boot host and instruction memory. Used to load programs, and to round-trip check the decoder (fields -> encoder -> decoder -> same fields).

Parameters:
- ADDR_W, 10, word-address width of instruction memory; depth = 2**ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_last  in  1  bundle is the final instruction of the session.
- in_kind  in  4  instruction class, KIND_* from shared package.
- in_alucode  in  6  ALU_* code, same encoding the decoder emits.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  sign-extended immediate, decoder convention.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- done  out  1  session finished cleanly; held high.
- err  out  1  session aborted; held high.
- err_code  out  2  0 none, 1 illegal alucode/kind pair, 2 immediate out of range, 3 memory full.

Behaviour:
- Reset: state IDLE. in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, err_code=0. Address counter = BASE_ADDR.
- FSM states: IDLE, LOAD, DONE, ERR.
  - IDLE -> LOAD on start.
  - In DONE or ERR, start clears done/err/err_code, reloads the counter to BASE_ADDR, and moves to LOAD.
  - start while in LOAD restarts the session the same way. Any bundle presented in that same cycle is ignored.
- in_ready = 1 only in LOAD. A bundle is accepted on in_valid & in_ready.
- Latency: encoding is combinational. imem_we/addr/wdata are registered and assert exactly one cycle after acceptance. imem_we is a single-cycle pulse per accepted bundle. Back-to-back acceptance gives one write per cycle.
- Encoding by kind:
  - OP: opcode 0110011; funct3/funct7 from alucode. ADD/SUB and SRL/SRA are distinguished by funct7 0000000/0100000.
  - OPIMM: opcode 0010011; imm[11:0] in ir[31:20].
    - SLL/SRL/SRA: shamt=imm[4:0]; funct7 0000000, or 0100000 for SRA.
    - SUB is illegal.
  - LUI (0110111) / AUIPC (0010111): ir[31:12]=imm[31:12].
  - JAL (1101111): J-type scatter of imm[20:1].
  - JALR (1100111): funct3 000, I-type.
  - BRANCH (1100011): B-type scatter of imm[12:1]; funct3 from ALU_BEQ..ALU_BGEU.
  - LOAD (0000011): I-type; funct3 from ALU_LB..ALU_LHU.
  - STORE (0100011): S-type; funct3 from ALU_SB/SH/SW.
  - HALT: fixed word 0x00000073 (ecall).
- Unused register fields encode as 0 regardless of input.
- Range checks, err_code 2:
  - I/S-type imm must equal sext(imm[11:0]).
  - Shift imm must be in 0..31.
  - B-type imm must be in -4096..4094 and even.
  - J-type imm must be in +-1 MiB and even.
  - LUI/AUIPC imm[11:0] must be 0.
- Illegal pair or unknown kind: err_code 1.
- On any error: no write occurs, err=1, state -> ERR, in_ready drops the next cycle.
- Address counter increments after every write and wraps modulo 2**ADDR_W.
- Memory full: if 2**ADDR_W words have already been written this session, the next accepted bundle is not written; err_code 3, ERR.
- in_last on a legal bundle: the word is written, then state -> DONE and done rises in the same cycle as that imem_we.
- Reset mid-session returns everything to reset values immediately, asynchronously. A write issued in that cycle is lost.

Optional Feature:
- Macro ENCODER_CHECKSUM_EN.
- When defined:
  - Adds output checksum (32): running sum modulo 2**32 of every word written this session.
  - Reset and start both clear it to 0.
  - It updates in the same cycle as imem_we and is stable once done.
- When undefined: the port is absent and no adder is generated.

Decomposition:
- Shared package (extend define.vh): KIND_* constants; opcode constants (OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, SYSTEM); ERR_* codes.
- ALU_* codes come from the existing defines, unchanged.
- One sub-module, instr_word_encoder: purely combinational fields -> {word, illegal, range_err}.
- The top holds the FSM, counter, output registers and checksum.

Test Plan:
- start, then OPIMM ADD rd=1 rs1=0 imm=5 -> one cycle later imem_we=1, addr=0, wdata=0x00500093.
- Back-to-back OP ADD (rd=3, rs1=1, rs2=2), then OP SUB with same regs, with in_last on the second -> wdata 0x002081B3 at addr 0, 0x402081B3 at addr 1; done rises with the second write.
- LOAD LW rd=5 rs1=2 imm=8; STORE SW rs1=2 rs2=5 imm=12; BRANCH BEQ rs1=1 rs2=2 imm=-4; LUI rd=1 imm=0x12345000 -> 0x00812283, 0x00512623, 0xFE208EE3, 0x123450B7.
- OPIMM SLL imm=32 -> no write, err=1, err_code=2, in_ready=0; then start -> err clears, next write at BASE_ADDR.
- ADDR_W=2: five legal bundles, no in_last -> writes to 0..3, fifth aborted with err_code=3; OP kind with ALU_LW -> err_code=1.
- Assert rst during a burst of writes -> all outputs 0 immediately; with ENCODER_CHECKSUM_EN, the checksum equals the sum of the words written so far and is 0 after reset.
